// File: rtl/bram_shift_pkg.sv
// Shared types and helpers for the circular BRAM shift register.
package bram_shift_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN
    } state_e;

    localparam logic MODE_PLAYBACK = 1'b0;
    localparam logic MODE_DELAY    = 1'b1;

    // Zero or out-of-range lengths select the full memory depth.
    function automatic int unsigned eff_length(input int unsigned length,
                                               input int unsigned addr_width);
        int unsigned depth;
        depth = 32'd1 << addr_width;
        if ((length == 0) || (length > depth)) begin
            return depth;
        end
        return length;
    endfunction

endpackage

// File: rtl/bram_sp_rf.sv
// Single-port read-first block RAM with a registered read port.
module bram_sp_rf #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned ADDR_WIDTH = 9
) (
    input  logic                  clock,
    input  logic                  en,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] din,
    output logic [DATA_WIDTH-1:0] dout
);

    (* ram_style = "block" *) logic [DATA_WIDTH-1:0] mem [0:(1 << ADDR_WIDTH)-1];

    // Read-first: a write returns the word it replaces.
    always_ff @(posedge clock) begin
        if (en) begin
            if (we) begin
                mem[addr] <= din;
            end
            dout <= mem[addr];
        end
    end

endmodule

// File: rtl/bram_shift_register.sv
// Circular BRAM buffer: looping ROM playback or programmable-length delay line.
module bram_shift_register
    import bram_shift_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned CHANNELS   = 1,
    parameter int unsigned ADDR_WIDTH = 9
) (
    input  logic                           clock,
    input  logic                           reset_n,
    input  logic                           mode,
    input  logic [ADDR_WIDTH:0]            length,
    input  logic                           start,
    input  logic                           stop,
    input  logic                           load_en,
    input  logic [ADDR_WIDTH-1:0]          load_addr,
    input  logic [CHANNELS*DATA_WIDTH-1:0] load_data,
    input  logic                           in_valid,
    input  logic [CHANNELS*DATA_WIDTH-1:0] in_data,
    output logic                           out_valid,
    output logic [CHANNELS*DATA_WIDTH-1:0] out_data,
    output logic                           wrap,
    output logic                           busy
);

    localparam int unsigned WordWidth = CHANNELS * DATA_WIDTH;
    localparam int unsigned Depth     = 1 << ADDR_WIDTH;

    state_e                 state_q, state_d;
    logic                   drain_q, drain_d;
    logic                   mode_q, mode_d;
    logic [ADDR_WIDTH:0]    len_q, len_d;
    logic [ADDR_WIDTH-1:0]  ptr_q, ptr_d;
    logic [ADDR_WIDTH:0]    prime_q, prime_d;
    logic                   s1_valid_q, s1_valid_d;
    logic                   s1_wrap_q, s1_wrap_d;
    logic                   out_valid_q, out_valid_d;
    logic                   out_wrap_q, out_wrap_d;
    logic [WordWidth-1:0]   out_data_q, out_data_d;

    logic [ADDR_WIDTH:0]    len_eff;
    logic                   advance;
    logic                   last;
    logic                   adv_valid;

    logic                   ram_en;
    logic                   ram_we;
    logic [ADDR_WIDTH-1:0]  ram_addr;
    logic [WordWidth-1:0]   ram_din;
    logic [WordWidth-1:0]   ram_dout;

    assign len_eff   = (ADDR_WIDTH + 1)'(eff_length(32'(length), ADDR_WIDTH));
    // A start in RUN takes priority over any advance in the same cycle.
    assign advance   = (state_q == RUN) && in_valid && !start;
    assign last      = ({1'b0, ptr_q} == (len_q - 1'b1));
    assign adv_valid = (mode_q == MODE_PLAYBACK) || (prime_q == len_q);

    // Memory port: preload owns it in IDLE, the run pointer otherwise.
    always_comb begin
        ram_en   = 1'b0;
        ram_we   = 1'b0;
        ram_addr = ptr_q;
        ram_din  = in_data;
        if (state_q == IDLE) begin
            ram_en   = load_en;
            ram_we   = load_en;
            ram_addr = load_addr;
            ram_din  = load_data;
        end else begin
            ram_en = advance;
            ram_we = advance && (mode_q == MODE_DELAY);
        end
    end

    bram_sp_rf #(
        .DATA_WIDTH (WordWidth),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_ram (
        .clock (clock),
        .en    (ram_en),
        .we    (ram_we),
        .addr  (ram_addr),
        .din   (ram_din),
        .dout  (ram_dout)
    );

    // Control FSM next state; DRAIN lasts two cycles to flush the read pipeline.
    always_comb begin
        state_d = state_q;
        drain_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) state_d = RUN;
            end
            RUN: begin
                if (start)     state_d = RUN;
                else if (stop) state_d = DRAIN;
            end
            DRAIN: begin
                if (start)        state_d = RUN;
                else if (drain_q) state_d = IDLE;
                else              drain_d = 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    // Configuration latch, circular pointer and saturating prime counter.
    always_comb begin
        mode_d  = mode_q;
        len_d   = len_q;
        ptr_d   = ptr_q;
        prime_d = prime_q;
        if (start) begin
            mode_d  = mode;
            len_d   = len_eff;
            ptr_d   = '0;
            prime_d = '0;
        end else if (advance) begin
            ptr_d = last ? '0 : ptr_q + 1'b1;
            if (prime_q != len_q) begin
                prime_d = prime_q + 1'b1;
            end
        end
    end

    // Two-stage output pipeline; start squashes whatever is in flight.
    always_comb begin
        s1_valid_d  = advance && adv_valid;
        s1_wrap_d   = advance && adv_valid && last;
        out_valid_d = s1_valid_q && !start;
        out_wrap_d  = s1_wrap_q && !start;
        out_data_d  = out_valid_d ? ram_dout : out_data_q;
    end

    // State and pipeline registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            drain_q     <= 1'b0;
            mode_q      <= MODE_PLAYBACK;
            len_q       <= (ADDR_WIDTH + 1)'(Depth);
            ptr_q       <= '0;
            prime_q     <= '0;
            s1_valid_q  <= 1'b0;
            s1_wrap_q   <= 1'b0;
            out_valid_q <= 1'b0;
            out_wrap_q  <= 1'b0;
            out_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            drain_q     <= drain_d;
            mode_q      <= mode_d;
            len_q       <= len_d;
            ptr_q       <= ptr_d;
            prime_q     <= prime_d;
            s1_valid_q  <= s1_valid_d;
            s1_wrap_q   <= s1_wrap_d;
            out_valid_q <= out_valid_d;
            out_wrap_q  <= out_wrap_d;
            out_data_q  <= out_data_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign wrap      = out_wrap_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_bram_shift_register.sv
// Self-checking bench for bram_shift_register (default parameters).
module tb_bram_shift_register;

    logic        clock;
    logic        reset_n;
    logic        mode;
    logic [9:0]  length;
    logic        start;
    logic        stop;
    logic        load_en;
    logic [8:0]  load_addr;
    logic [15:0] load_data;
    logic        in_valid;
    logic [15:0] in_data;
    logic        out_valid;
    logic [15:0] out_data;
    logic        wrap;
    logic        busy;

    int checks   = 0;
    int failures = 0;

    bram_shift_register dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .mode      (mode),
        .length    (length),
        .start     (start),
        .stop      (stop),
        .load_en   (load_en),
        .load_addr (load_addr),
        .load_data (load_data),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_data  (out_data),
        .wrap      (wrap),
        .busy      (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic        st;
        logic        sp;
        logic        md;
        logic [9:0]  ln;
        logic        iv;
        logic [15:0] di;
        logic        ev;
        logic [15:0] ed;
        logic        cd;
        logic        ew;
        logic        eb;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic st, input logic sp, input logic md, input logic [9:0] ln,
                       input logic iv, input logic [15:0] di, input logic ev,
                       input logic [15:0] ed, input logic cd, input logic ew, input logic eb);
        vec_t v;
        v.st = st; v.sp = sp; v.md = md; v.ln = ln; v.iv = iv; v.di = di;
        v.ev = ev; v.ed = ed; v.cd = cd; v.ew = ew; v.eb = eb;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input int idx, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s[%0d] got=%0d want=%0d", name, idx, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic go_idle(input string name);
        stop = 1'b1; in_valid = 1'b0;
        tick();
        stop = 1'b0;
        tick();
        tick();
        check(name, 0, 32'(busy), 32'd0);
    endtask

    task automatic preload();
        for (int i = 0; i < 4; i++) begin
            load_en = 1'b1; load_addr = 9'(i); load_data = 16'(100 + i);
            tick();
        end
        load_en = 1'b0;
    endtask

    // Start a delay line and compare against an input history with two-cycle latency.
    task automatic run_delay(input string name, input logic [9:0] prog_len, input int eff_len,
                             input int n, input bit gapped, input int seed);
        logic [15:0] hist[$];
        logic        s1_v, nv;
        logic [15:0] s1_d, nd;
        int          adv;
        start = 1'b1; mode = 1'b1; length = prog_len; in_valid = 1'b0;
        tick();
        start = 1'b0;
        check(name, -1, 32'(out_valid), 32'd0);
        s1_v = 1'b0; s1_d = '0; adv = 0;
        for (int c = 0; c < n + 2; c++) begin
            in_valid = (c < n) && (!gapped || (c % 2 == 0));
            in_data  = 16'(seed + c * 7);
            nv = 1'b0; nd = '0;
            if (in_valid) begin
                if (adv >= eff_len) begin
                    nv = 1'b1;
                    nd = hist[adv - eff_len];
                end
                hist.push_back(in_data);
                adv++;
            end
            tick();
            check(name, c, 32'(out_valid), 32'(s1_v));
            if (s1_v) check(name, c, 32'(out_data), 32'(s1_d));
            s1_v = nv; s1_d = nd;
        end
        in_valid = 1'b0;
    endtask

    // Start playback with L=4 over mem[i]=100+i and check n advances.
    task automatic play_seq(input string name, input int n);
        logic s1_v, s1_w, nv, nw;
        logic [15:0] s1_d, nd;
        start = 1'b1; mode = 1'b0; length = 10'd4; in_valid = 1'b0;
        tick();
        start = 1'b0;
        check(name, -1, 32'(busy), 32'd1);
        s1_v = 1'b0; s1_w = 1'b0; s1_d = '0;
        for (int c = 0; c < n + 2; c++) begin
            in_valid = (c < n);
            nv = in_valid; nw = in_valid && (c % 4 == 3); nd = 16'(100 + c % 4);
            tick();
            check(name, c, 32'(out_valid), 32'(s1_v));
            check(name, c, 32'(wrap), 32'(s1_w));
            if (s1_v) check(name, c, 32'(out_data), 32'(s1_d));
            s1_v = nv; s1_w = nw; s1_d = nd;
        end
        in_valid = 1'b0;
    endtask

    initial begin
        reset_n = 1'b0; mode = 1'b0; length = '0; start = 1'b0; stop = 1'b0;
        load_en = 1'b0; load_addr = '0; load_data = '0; in_valid = 1'b0; in_data = '0;
        tick();
        tick();
        reset_n = 1'b1;
        tick();
        check("rst_valid", 0, 32'(out_valid), 32'd0);
        check("rst_data", 0, 32'(out_data), 32'd0);
        check("rst_wrap", 0, 32'(wrap), 32'd0);
        check("rst_busy", 0, 32'(busy), 32'd0);

        preload();

        // Playback L=4: ten advances, then stop and drain.
        add(1, 0, 0, 4, 0, 0, 0, 0,   0, 0, 1);
        add(0, 0, 0, 4, 1, 0, 0, 0,   0, 0, 1);
        add(0, 0, 0, 4, 1, 0, 1, 100, 1, 0, 1);
        add(0, 0, 0, 4, 1, 0, 1, 101, 1, 0, 1);
        add(0, 0, 0, 4, 1, 0, 1, 102, 1, 0, 1);
        add(0, 0, 0, 4, 1, 0, 1, 103, 1, 1, 1);
        add(0, 0, 0, 4, 1, 0, 1, 100, 1, 0, 1);
        add(0, 0, 0, 4, 1, 0, 1, 101, 1, 0, 1);
        add(0, 0, 0, 4, 1, 0, 1, 102, 1, 0, 1);
        add(0, 0, 0, 4, 1, 0, 1, 103, 1, 1, 1);
        add(0, 0, 0, 4, 1, 0, 1, 100, 1, 0, 1);
        add(0, 0, 0, 4, 0, 0, 1, 101, 1, 0, 1);
        add(0, 0, 0, 4, 0, 0, 0, 101, 1, 0, 1);
        add(0, 1, 0, 4, 0, 0, 0, 101, 1, 0, 1);
        add(0, 0, 0, 4, 0, 0, 0, 101, 1, 0, 1);
        add(0, 0, 0, 4, 0, 0, 0, 101, 1, 0, 0);
        // Delay L=3 with inputs 1..8: three primed slots, then 1..5.
        add(1, 0, 1, 3, 0, 0, 0, 0, 0, 0, 1);
        add(0, 0, 1, 3, 1, 1, 0, 0, 0, 0, 1);
        add(0, 0, 1, 3, 1, 2, 0, 0, 0, 0, 1);
        add(0, 0, 1, 3, 1, 3, 0, 0, 0, 0, 1);
        add(0, 0, 1, 3, 1, 4, 0, 0, 0, 0, 1);
        add(0, 0, 1, 3, 1, 5, 1, 1, 1, 0, 1);
        add(0, 0, 1, 3, 1, 6, 1, 2, 1, 0, 1);
        add(0, 0, 1, 3, 1, 7, 1, 3, 1, 1, 1);
        add(0, 0, 1, 3, 1, 8, 1, 4, 1, 0, 1);
        add(0, 0, 1, 3, 0, 0, 1, 5, 1, 0, 1);
        add(0, 0, 1, 3, 0, 0, 0, 5, 1, 0, 1);

        foreach (vecs[i]) begin
            start = vecs[i].st; stop = vecs[i].sp; mode = vecs[i].md; length = vecs[i].ln;
            in_valid = vecs[i].iv; in_data = vecs[i].di;
            tick();
            check("vec_valid", i, 32'(out_valid), 32'(vecs[i].ev));
            check("vec_wrap", i, 32'(wrap), 32'(vecs[i].ew));
            check("vec_busy", i, 32'(busy), 32'(vecs[i].eb));
            if (vecs[i].cd) check("vec_data", i, 32'(out_data), 32'(vecs[i].ed));
        end
        start = 1'b0; stop = 1'b0; in_valid = 1'b0;
        go_idle("idle_after_table");

        run_delay("gap_l2", 10'd2, 2, 14, 1'b1, 500);
        go_idle("idle_gap");
        run_delay("delay_l1", 10'd1, 1, 8, 1'b0, 900);
        go_idle("idle_l1");
        run_delay("delay_l0", 10'd0, 512, 520, 1'b0, 3000);
        go_idle("idle_l0");
        run_delay("delay_l600", 10'd600, 512, 520, 1'b0, 7000);
        go_idle("idle_l600");

        // Load while busy must not touch memory.
        preload();
        start = 1'b1; mode = 1'b0; length = 10'd4;
        tick();
        start = 1'b0;
        load_en = 1'b1; load_addr = 9'd0; load_data = 16'hDEAD;
        tick();
        load_en = 1'b0;
        go_idle("idle_load");
        play_seq("load_busy", 4);

        // Stop mid-run: two in-flight words, then busy drops.
        start = 1'b1; mode = 1'b0; length = 10'd4; in_valid = 1'b0;
        tick();
        start = 1'b0; in_valid = 1'b1;
        tick();
        tick();
        tick();
        stop = 1'b1;
        tick();
        stop = 1'b0;
        check("stop_v0", 0, 32'(out_valid), 32'd1);
        check("stop_d0", 0, 32'(out_data), 32'd102);
        check("stop_b0", 0, 32'(busy), 32'd1);
        tick();
        check("stop_v1", 0, 32'(out_valid), 32'd1);
        check("stop_d1", 0, 32'(out_data), 32'd103);
        check("stop_w1", 0, 32'(wrap), 32'd1);
        check("stop_b1", 0, 32'(busy), 32'd1);
        tick();
        check("stop_v2", 0, 32'(out_valid), 32'd0);
        check("stop_b2", 0, 32'(busy), 32'd0);
        in_valid = 1'b0;
        tick();
        check("stop_v3", 0, 32'(out_valid), 32'd0);

        // start and stop together: restart from pointer 0, in-flight words dropped.
        start = 1'b1; mode = 1'b0; length = 10'd4;
        tick();
        start = 1'b0; in_valid = 1'b1;
        tick();
        tick();
        start = 1'b1; stop = 1'b1;
        tick();
        start = 1'b0; stop = 1'b0;
        check("ss_b0", 0, 32'(busy), 32'd1);
        check("ss_v0", 0, 32'(out_valid), 32'd0);
        tick();
        check("ss_v1", 0, 32'(out_valid), 32'd0);
        tick();
        check("ss_v2", 0, 32'(out_valid), 32'd1);
        check("ss_d2", 0, 32'(out_data), 32'd100);
        tick();
        check("ss_d3", 0, 32'(out_data), 32'd101);
        in_valid = 1'b0;

        // Asynchronous reset mid-run, then replay the preloaded words.
        #3 reset_n = 1'b0;
        #1;
        check("arst_valid", 0, 32'(out_valid), 32'd0);
        check("arst_data", 0, 32'(out_data), 32'd0);
        check("arst_wrap", 0, 32'(wrap), 32'd0);
        check("arst_busy", 0, 32'(busy), 32'd0);
        #1 reset_n = 1'b1;
        tick();
        play_seq("replay", 6);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
